// File: rtl/aes_sbox_pipe.sv
// Two-stage pipelined AES SubBytes / InvSubBytes engine over N_BYTES independent lanes.
// Optional self-check stage with sticky o_fault port when AES_SBOX_FAULT_CHK_EN is defined.
module aes_sbox_pipe #(
   parameter int N_BYTES = 4,
   parameter int TAG_W   = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic                 i_mode,
   input  logic [8*N_BYTES-1:0] i_data,
   input  logic [TAG_W-1:0]     i_tag,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [8*N_BYTES-1:0] o_data,
   output logic [TAG_W-1:0]     o_tag,
   output logic                 o_mode,
   output logic                 o_busy
`ifdef AES_SBOX_FAULT_CHK_EN
   ,
   output logic                 o_fault
`endif
);

   localparam int DW = 8 * N_BYTES;

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Inverse as b^254 built from the squares b^2..b^128; 0 maps to 0 naturally.
   function automatic logic [7:0] gf_inv(input logic [7:0] b);
      logic [7:0] sq;
      logic [7:0] r;
      sq = b;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
   endfunction

   logic             adv2;
   logic             ready;
   logic             load1;

   logic             v1_q, v1_d;
   logic [DW-1:0]    s1_data_q, s1_data_d;
   logic             s1_mode_q, s1_mode_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic             v2_q, v2_d;
   logic [DW-1:0]    s2_data_q, s2_data_d;
   logic             s2_mode_q, s2_mode_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // ready never depends on valid, and valid never drops without a transfer.
   always_comb begin
      adv2  = v1_q & (~v2_q | i_ready);
      ready = ~v1_q | adv2;
      load1 = i_valid & ready;

      v1_d = v1_q;
      if (load1)     v1_d = 1'b1;
      else if (adv2) v1_d = 1'b0;

      v2_d = v2_q;
      if (adv2)         v2_d = 1'b1;
      else if (i_ready) v2_d = 1'b0;

      s1_data_d = s1_data_q;
      s1_mode_d = s1_mode_q;
      s1_tag_d  = s1_tag_q;
      if (load1) begin
         s1_mode_d = i_mode;
         s1_tag_d  = i_tag;
         for (int k = 0; k < N_BYTES; k++) begin
            s1_data_d[8*k +: 8] = i_mode ? inv_affine(i_data[8*k +: 8]) : i_data[8*k +: 8];
         end
      end

      s2_data_d = s2_data_q;
      s2_mode_d = s2_mode_q;
      s2_tag_d  = s2_tag_q;
      if (adv2) begin
         s2_mode_d = s1_mode_q;
         s2_tag_d  = s1_tag_q;
         for (int k = 0; k < N_BYTES; k++) begin
            s2_data_d[8*k +: 8] = s1_mode_q ? gf_inv(s1_data_q[8*k +: 8])
                                            : affine(gf_inv(s1_data_q[8*k +: 8]));
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         v1_q      <= 1'b0;
         s1_data_q <= '0;
         s1_mode_q <= 1'b0;
         s1_tag_q  <= '0;
         v2_q      <= 1'b0;
         s2_data_q <= '0;
         s2_mode_q <= 1'b0;
         s2_tag_q  <= '0;
      end else begin
         v1_q      <= v1_d;
         s1_data_q <= s1_data_d;
         s1_mode_q <= s1_mode_d;
         s1_tag_q  <= s1_tag_d;
         v2_q      <= v2_d;
         s2_data_q <= s2_data_d;
         s2_mode_q <= s2_mode_d;
         s2_tag_q  <= s2_tag_d;
      end
   end

   assign o_ready = ready;
   assign o_valid = v2_q;
   assign o_data  = s2_data_q;
   assign o_tag   = s2_tag_q;
   assign o_mode  = s2_mode_q;
   assign o_busy  = v1_q | v2_q;

`ifdef AES_SBOX_FAULT_CHK_EN
   logic [DW-1:0] s1_orig_q, s1_orig_d;
   logic [DW-1:0] s2_orig_q, s2_orig_d;
   logic          chk_v_q, chk_v_d;
   logic [DW-1:0] chk_data_q, chk_data_d;
   logic [DW-1:0] chk_orig_q, chk_orig_d;
   logic          chk_mode_q, chk_mode_d;
   logic          fault_q, fault_d;
   logic          mismatch;
   logic [7:0]    back;

   // Each delivered result is run back through the opposite transform and must
   // reproduce the byte that entered the pipe.
   always_comb begin
      s1_orig_d = load1 ? i_data : s1_orig_q;
      s2_orig_d = adv2 ? s1_orig_q : s2_orig_q;

      chk_v_d    = v2_q & i_ready;
      chk_data_d = chk_data_q;
      chk_orig_d = chk_orig_q;
      chk_mode_d = chk_mode_q;
      if (chk_v_d) begin
         chk_data_d = s2_data_q;
         chk_orig_d = s2_orig_q;
         chk_mode_d = s2_mode_q;
      end

      mismatch = 1'b0;
      back     = 8'h00;
      for (int k = 0; k < N_BYTES; k++) begin
         back = chk_mode_q ? affine(gf_inv(chk_data_q[8*k +: 8]))
                           : gf_inv(inv_affine(chk_data_q[8*k +: 8]));
         if (back != chk_orig_q[8*k +: 8]) mismatch = 1'b1;
      end
      fault_d = fault_q | (chk_v_q & mismatch);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_orig_q  <= '0;
         s2_orig_q  <= '0;
         chk_v_q    <= 1'b0;
         chk_data_q <= '0;
         chk_orig_q <= '0;
         chk_mode_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         s1_orig_q  <= s1_orig_d;
         s2_orig_q  <= s2_orig_d;
         chk_v_q    <= chk_v_d;
         chk_data_q <= chk_data_d;
         chk_orig_q <= chk_orig_d;
         chk_mode_q <= chk_mode_d;
         fault_q    <= fault_d;
      end
   end

   assign o_fault = fault_q;
`endif

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Scoreboard bench for aes_sbox_pipe: 4-lane main instance plus 1- and 16-lane
// instances for the exhaustive table sweep; expected values come from the FIPS-197 table.
`timescale 1ns/1ps
module tb_aes_sbox_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  logic [7:0] isbox [256];

  function automatic logic [7:0] ref_byte(input logic m, input logic [7:0] b);
    return m ? isbox[b] : SBOX[b];
  endfunction

  function automatic logic [31:0] sub4(input logic m, input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_byte(m, d[8*k +: 8]);
    return r;
  endfunction

  typedef struct {
    logic [127:0] data;
    logic [3:0]   tag;
    logic         mode;
    logic         lat_chk;
    int           cyc;
  } exp_t;

  exp_t exp4_q[$];
  exp_t exp1_q[$];
  exp_t exp16_q[$];
  exp_t m4, m1, m16, item;

  // ---------------- DUT signals ----------------
  logic iv4, or4, im4, ov4, ir4, om4, busy4;
  logic [31:0] id4, od4;
  logic [3:0]  it4, ot4;
  logic iv1, or1, im1, ov1, ir1, om1, busy1;
  logic [7:0]  id1, od1;
  logic [3:0]  it1, ot1;
  logic iv16, or16, im16, ov16, ir16, om16, busy16;
  logic [127:0] id16, od16;
  logic [3:0]   it16, ot16;
`ifdef AES_SBOX_FAULT_CHK_EN
  logic fault4, fault1, fault16;
`endif

  aes_sbox_pipe #(.N_BYTES(4), .TAG_W(4)) u_dut4 (
`ifdef AES_SBOX_FAULT_CHK_EN
    .o_fault(fault4),
`endif
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv4), .o_ready(or4), .i_mode(im4),
    .i_data(id4), .i_tag(it4), .o_valid(ov4), .i_ready(ir4), .o_data(od4),
    .o_tag(ot4), .o_mode(om4), .o_busy(busy4));

  aes_sbox_pipe #(.N_BYTES(1), .TAG_W(4)) u_dut1 (
`ifdef AES_SBOX_FAULT_CHK_EN
    .o_fault(fault1),
`endif
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv1), .o_ready(or1), .i_mode(im1),
    .i_data(id1), .i_tag(it1), .o_valid(ov1), .i_ready(ir1), .o_data(od1),
    .o_tag(ot1), .o_mode(om1), .o_busy(busy1));

  aes_sbox_pipe #(.N_BYTES(16), .TAG_W(4)) u_dut16 (
`ifdef AES_SBOX_FAULT_CHK_EN
    .o_fault(fault16),
`endif
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv16), .o_ready(or16), .i_mode(im16),
    .i_data(id16), .i_tag(it16), .o_valid(ov16), .i_ready(ir16), .o_data(od16),
    .o_tag(ot16), .o_mode(om16), .o_busy(busy16));

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    if (sel == 4) return exp4_q.size();
    if (sel == 1) return exp1_q.size();
    return exp16_q.size();
  endfunction

  task automatic drain(input int sel);
    int g = 0;
    while (qsize(sel) != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #1;
    check($sformatf("drain%0d_queue_empty", sel), 128'(qsize(sel)), 128'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic send4(input logic m, input logic [31:0] d, input logic [3:0] t,
                       input logic [31:0] e, input logic lat);
    int g = 0;
    iv4 = 1'b1; im4 = m; id4 = d; it4 = t;
    @(negedge clk);
    while (!or4 && g < 100) begin g++; @(negedge clk); end
    if (!or4) begin
      n_vec++; n_fail++;
      $display("FAIL send4_accept_timeout: got o_ready=0 expected 1");
    end else begin
      item.data = {96'b0, e}; item.tag = t; item.mode = m; item.lat_chk = lat; item.cyc = cyc;
      exp4_q.push_back(item);
    end
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic send1(input logic m, input logic [7:0] d, input logic [3:0] t, input logic [7:0] e);
    int g = 0;
    iv1 = 1'b1; im1 = m; id1 = d; it1 = t;
    @(negedge clk);
    while (!or1 && g < 100) begin g++; @(negedge clk); end
    if (!or1) begin
      n_vec++; n_fail++;
      $display("FAIL send1_accept_timeout: got o_ready=0 expected 1");
    end else begin
      item.data = {120'b0, e}; item.tag = t; item.mode = m; item.lat_chk = 1'b0; item.cyc = cyc;
      exp1_q.push_back(item);
    end
    @(posedge clk); #1;
    iv1 = 1'b0;
  endtask

  task automatic send16(input logic m, input logic [127:0] d, input logic [3:0] t, input logic [127:0] e);
    int g = 0;
    iv16 = 1'b1; im16 = m; id16 = d; it16 = t;
    @(negedge clk);
    while (!or16 && g < 100) begin g++; @(negedge clk); end
    if (!or16) begin
      n_vec++; n_fail++;
      $display("FAIL send16_accept_timeout: got o_ready=0 expected 1");
    end else begin
      item.data = e; item.tag = t; item.mode = m; item.lat_chk = 1'b0; item.cyc = cyc;
      exp16_q.push_back(item);
    end
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  // Random output backpressure on the single-lane instance.
  logic bp1_en = 1'b0;
  initial begin
    ir1 = 1'b1;
    forever begin
      @(posedge clk); #1;
      ir1 = bp1_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n && ov4 && ir4) begin
      n_vec++;
      if (exp4_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon4_unexpected_output: got data %h expected none", od4);
      end else begin
        m4 = exp4_q.pop_front();
        if (od4 !== m4.data[31:0] || ot4 !== m4.tag || om4 !== m4.mode) begin
          n_fail++;
          $display("FAIL mon4_output: got %h/%h/%b expected %h/%h/%b",
                   od4, ot4, om4, m4.data[31:0], m4.tag, m4.mode);
        end
        if (m4.lat_chk) begin
          n_vec++;
          if (cyc - m4.cyc != 2) begin
            n_fail++;
            $display("FAIL mon4_latency: got %0d expected 2", cyc - m4.cyc);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov1 && ir1) begin
      n_vec++;
      if (exp1_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon1_unexpected_output: got data %h expected none", od1);
      end else begin
        m1 = exp1_q.pop_front();
        if (od1 !== m1.data[7:0] || ot1 !== m1.tag || om1 !== m1.mode) begin
          n_fail++;
          $display("FAIL mon1_output: got %h/%h/%b expected %h/%h/%b",
                   od1, ot1, om1, m1.data[7:0], m1.tag, m1.mode);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov16 && ir16) begin
      n_vec++;
      if (exp16_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon16_unexpected_output: got data %h expected none", od16);
      end else begin
        m16 = exp16_q.pop_front();
        if (od16 !== m16.data || ot16 !== m16.tag || om16 !== m16.mode) begin
          n_fail++;
          $display("FAIL mon16_output: got %h/%h/%b expected %h/%h/%b",
                   od16, ot16, om16, m16.data, m16.tag, m16.mode);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0]  t3_data [8];
  logic [127:0] w16_d, w16_e;

  initial begin
    t3_data = '{32'h19a09ae9, 32'hd4e0b81e, 32'h3df4c6f8, 32'h27bfb441,
                32'he3e2cf1b, 32'h11982ddb, 32'hbe2b2a08, 32'hfe0c5a7d};
    for (int i = 0; i < 256; i++) isbox[SBOX[i]] = 8'(i);

    rst_n = 1'b0;
    iv4 = 1'b0; im4 = 1'b0; id4 = '0; it4 = '0; ir4 = 1'b1;
    iv1 = 1'b0; im1 = 1'b0; id1 = '0; it1 = '0;
    iv16 = 1'b0; im16 = 1'b0; id16 = '0; it16 = '0; ir16 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_o_valid", 128'(ov4), 128'd0);
    check("rst_o_busy", 128'(busy4), 128'd0);
    check("rst_o_data", 128'(od4), 128'd0);
    check("rst_o_tag_mode", 128'({ot4, om4}), 128'd0);
    check("rst_o_ready", 128'(or4), 128'd1);
    check("rst_dut16_busy", 128'(busy16), 128'd0);
    @(posedge clk); #1;

    // forward and inverse directed vectors, back to back, latency checked
    send4(1'b0, 32'h0053FF01, 4'hA, 32'h63ED167C, 1'b1);
    send4(1'b1, 32'h63ED167C, 4'h5, 32'h0053FF01, 1'b1);
    send4(1'b1, 32'h0000FFFF, 4'h6, 32'h52527D7D, 1'b1);
    drain(4);

    // 8 back-to-back transactions with alternating modes
    for (int i = 0; i < 8; i++) begin
      send4(i[0], t3_data[i], 4'(i), sub4(i[0], t3_data[i]), 1'b1);
    end
    drain(4);

    // backpressure: two accepts, then o_ready low and output stable
    ir4 = 1'b0;
    send4(1'b0, 32'h00112233, 4'h1, 32'h638293C3, 1'b0);
    send4(1'b0, 32'h44556677, 4'h2, sub4(1'b0, 32'h44556677), 1'b0);
    iv4 = 1'b1; im4 = 1'b1; id4 = 32'h8899AABB; it4 = 4'h3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_o_ready_low", 128'(or4), 128'd0);
      check("bp_o_valid_held", 128'(ov4), 128'd1);
      check("bp_o_data_stable", 128'({ot4, od4}), 128'({4'h1, 32'h638293C3}));
    end
    @(posedge clk); #1;
    ir4 = 1'b1;
    send4(1'b1, 32'h8899AABB, 4'h3, sub4(1'b1, 32'h8899AABB), 1'b0);
    drain(4);

    // reset with both stages full
    ir4 = 1'b0;
    send4(1'b0, 32'hDEADBEEF, 4'h7, sub4(1'b0, 32'hDEADBEEF), 1'b0);
    send4(1'b1, 32'hCAFEF00D, 4'h8, sub4(1'b1, 32'hCAFEF00D), 1'b0);
    @(negedge clk);
    check("full_o_busy", 128'(busy4), 128'd1);
    check("full_o_ready", 128'(or4), 128'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp4_q.delete();
    @(negedge clk);
    check("midrst_o_valid", 128'(ov4), 128'd0);
    check("midrst_o_busy", 128'(busy4), 128'd0);
    check("midrst_o_data", 128'(od4), 128'd0);
    check("midrst_o_tag_mode", 128'({ot4, om4}), 128'd0);
    check("midrst_o_ready", 128'(or4), 128'd1);
    @(posedge clk); #1;
    ir4 = 1'b1;
    send4(1'b0, 32'h0053FF01, 4'hC, 32'h63ED167C, 1'b1);
    drain(4);

    // exhaustive single-lane sweep under random backpressure
    bp1_en = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 256; i++) begin
        send1(m[0], 8'(i), 4'(i), ref_byte(m[0], 8'(i)));
      end
    end
    drain(1);
    bp1_en = 1'b0;

    // exhaustive 16-lane sweep, 16 bytes per transaction
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < 16; j++) begin
        for (int k = 0; k < 16; k++) begin
          w16_d[8*k +: 8] = 8'(16*j + k);
          w16_e[8*k +: 8] = ref_byte(m[0], 8'(16*j + k));
        end
        send16(m[0], w16_d, 4'(j), w16_e);
      end
    end
    drain(16);

`ifdef AES_SBOX_FAULT_CHK_EN
    check("fault4_clear", 128'(fault4), 128'd0);
    check("fault1_clear", 128'(fault1), 128'd0);
    check("fault16_clear", 128'(fault16), 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_vec++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
